pipeline_ctrl: RTL and testbench

- Central sequencer for the five-stage pipeline. Produces the per-latch write-enable and flush controls for ifid, idex, exmem and memwb, plus the PC enable.
- Resolves instruction-fetch and data-memory wait stalls, load-use hazards and taken branch/jump redirects.
- Sequences halt: drain, then freeze.
- Keeps cycle and stall performance counters.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/hazard_unit.sv | 25 ++
 rtl/pipeline_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and pipeline-controller state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_types_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } pctrl_state_t;

   // True when the MEM stage is performing any data access.
   function automatic logic mem_access(input logic ren, input logic wen);
      return ren | wen;
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// Detects load-use hazards between EX and ID, and data-memory wait stalls in MEM.
// Latency: purely combinational, same cycle.
// Backpressure: none; outputs feed the pipeline controller's priority logic.
module hazard_unit
   import cpu_types_pkg::*;
(
   input  logic     ld_ex,
   input  regbits_t wreg_ex,
   input  regbits_t rs_id,
   input  regbits_t rt_id,
   input  logic     dREN_mem,
   input  logic     dWEN_mem,
   input  logic     dhit,
   output logic     lu_hazard,
   output logic     mem_stall
);

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   always_comb begin
      lu_hazard = ld_ex && (wreg_ex != '0) &&
                  ((wreg_ex == rs_id) || (wreg_ex == rt_id));
      mem_stall = mem_access(dREN_mem, dWEN_mem) && !dhit;
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer: latch enables/flushes, PC enable, halt sequencing, perf counters.
// Latency: controls are combinational from inputs and state; halt and counters are registered.
// Backpressure: memory waits freeze upstream latches; fetch misses and load-use insert bubbles.
module pipeline_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 32
)(
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dREN_mem,
   input  logic             dWEN_mem,
   input  logic             halt_mem,
   input  logic             ld_ex,
   input  regbits_t         wreg_ex,
   input  regbits_t         rs_id,
   input  regbits_t         rt_id,
   input  logic             redirect_ex,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             halt,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   pctrl_state_t     state_q, state_d;
   logic             halt_q, halt_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             lu_hazard;
   logic             mem_stall;

   hazard_unit u_hazard (
      .ld_ex     (ld_ex),
      .wreg_ex   (wreg_ex),
      .rs_id     (rs_id),
      .rt_id     (rt_id),
      .dREN_mem  (dREN_mem),
      .dWEN_mem  (dWEN_mem),
      .dhit      (dhit),
      .lu_hazard (lu_hazard),
      .mem_stall (mem_stall)
   );

   // Priority-encoded latch controls, next state and counter updates.
   always_comb begin
      state_d     = state_q;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;

      unique case (state_q)
         RUN: begin
            if (mem_stall) begin
               // Hold everything up to EX/MEM; bubble into WB so the
               // stalled instruction is not written back twice.
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_en    = 1'b0;
               memwb_flush = 1'b1;
            end else if (halt_mem) begin
               // Squash everything younger than the halt and start draining.
               pc_en      = 1'b0;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               state_d    = DRAIN;
            end else if (redirect_ex) begin
               // Load the target even if the current fetch is still pending.
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (lu_hazard) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
            end else if (!ihit) begin
               pc_en      = 1'b0;
               ifid_flush = 1'b1;
            end
         end
         DRAIN: begin
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            if (!mem_stall) begin
               state_d = HALTED;
            end
         end
         HALTED: begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      halt_d = (state_d == HALTED);

      cycle_cnt_d = cycle_cnt_q;
      if (state_q != HALTED) begin
         cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      end

      // A halt in MEM deliberately stops fetch; that is not counted as a stall.
      stall_cnt_d = stall_cnt_q;
      if ((state_q == RUN) && !pc_en && !halt_mem) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // State, sticky halt and performance counters; all cleared asynchronously.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= RUN;
         halt_q      <= 1'b0;
         cycle_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         halt_q      <= halt_d;
         cycle_cnt_q <= cycle_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign halt      = halt_q;
   assign cycle_cnt = cycle_cnt_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic.
// Latency: controls checked mid-cycle, counters checked against a cycle-level model.
// Backpressure: n/a.
module tb_pipeline_ctrl;

   logic        CLK;
   logic        nRST;
   logic        ihit, dhit, dREN_mem, dWEN_mem, halt_mem, ld_ex, redirect_ex;
   logic [4:0]  wreg_ex, rs_id, rt_id;
   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
   logic [31:0] cycle_cnt, stall_cnt;

   // Reference model state: 0 running, 1 draining, 2 halted.
   int          m_state;
   logic        m_halt;
   logic [31:0] m_cyc, m_stall;

   int n_chk  = 0;
   int n_pass = 0;

   pipeline_ctrl #(.CNT_W(32)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .ihit        (ihit),
      .dhit        (dhit),
      .dREN_mem    (dREN_mem),
      .dWEN_mem    (dWEN_mem),
      .halt_mem    (halt_mem),
      .ld_ex       (ld_ex),
      .wreg_ex     (wreg_ex),
      .rs_id       (rs_id),
      .rt_id       (rt_id),
      .redirect_ex (redirect_ex),
      .pc_en       (pc_en),
      .ifid_en     (ifid_en),
      .idex_en     (idex_en),
      .exmem_en    (exmem_en),
      .memwb_en    (memwb_en),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .exmem_flush (exmem_flush),
      .memwb_flush (memwb_flush),
      .halt        (halt),
      .cycle_cnt   (cycle_cnt),
      .stall_cnt   (stall_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic model_mem_stall();
      return (dREN_mem || dWEN_mem) && !dhit;
   endfunction

   function automatic logic model_lu();
      return ld_ex && (wreg_ex != 5'd0) && (wreg_ex == rs_id || wreg_ex == rt_id);
   endfunction

   // Expected {pc_en, 4 en, 4 flush, halt} from the rule table.
   function automatic logic [9:0] model_ctrl();
      logic [4:0] en;   // pc, ifid, idex, exmem, memwb
      logic [3:0] fl;   // ifid, idex, exmem, memwb
      en = 5'b11111;
      fl = 4'b0000;
      if (m_state == 0) begin
         if (model_mem_stall())  begin en = 5'b00001; fl = 4'b0001; end
         else if (halt_mem)      begin en = 5'b01111; fl = 4'b1100; end
         else if (redirect_ex)   begin en = 5'b11111; fl = 4'b1100; end
         else if (model_lu())    begin en = 5'b00111; fl = 4'b0100; end
         else if (!ihit)         begin en = 5'b01111; fl = 4'b1000; end
      end else if (m_state == 1) begin
         en = 5'b01111;
         fl = 4'b1110;
      end else begin
         en = 5'b00000;
         fl = 4'b0000;
      end
      return {en, fl, m_halt};
   endfunction

   function automatic logic [9:0] dut_ctrl();
      return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
              ifid_flush, idex_flush, exmem_flush, memwb_flush, halt};
   endfunction

   // Called at posedge+1 with inputs already set; checks mid-cycle, then advances.
   task automatic run_cycle();
      logic [9:0] e, g;
      @(negedge CLK);
      e = model_ctrl();
      g = dut_ctrl();
      if (m_state == 1) begin
         // Upstream enables are irrelevant while their flush is asserted.
         e[8:6] = 3'b000;
         g[8:6] = 3'b000;
      end
      chk("ctrl", 64'(g), 64'(e));
      chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      if (m_state != 2) m_cyc++;
      if (m_state == 0) begin
         if (!e[9] && !halt_mem) m_stall++;
         if (!model_mem_stall() && halt_mem) m_state = 1;
      end else if (m_state == 1) begin
         if (!model_mem_stall()) begin
            m_state = 2;
            m_halt  = 1'b1;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      m_state = 0;
      m_halt  = 1'b0;
      m_cyc   = '0;
      m_stall = '0;
   endtask

   // Ends at posedge+1 with nRST released.
   task automatic do_reset();
      nRST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
      model_reset();
   endtask

   task automatic clean();
      ihit = 1'b1; dhit = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0;
      halt_mem = 1'b0; ld_ex = 1'b0; redirect_ex = 1'b0;
      wreg_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
   endtask

   task automatic rand_inputs();
      ihit        = ($urandom_range(0, 3) != 0);
      dhit        = ($urandom_range(0, 2) != 0);
      dREN_mem    = ($urandom_range(0, 3) == 0);
      dWEN_mem    = ($urandom_range(0, 5) == 0);
      halt_mem    = ($urandom_range(0, 119) == 0);
      ld_ex       = ($urandom_range(0, 2) == 0);
      redirect_ex = ($urandom_range(0, 5) == 0);
      wreg_ex     = 5'($urandom_range(0, 3));
      rs_id       = 5'($urandom_range(0, 3));
      rt_id       = 5'($urandom_range(0, 3));
   endtask

   initial begin
      clean();
      model_reset();
      do_reset();

      // Reset state and idle running.
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_cyc", 64'(cycle_cnt), 64'd0);
      repeat (10) run_cycle();
      chk("idle_cyc10", 64'(cycle_cnt), 64'd10);
      chk("idle_stall0", 64'(stall_cnt), 64'd0);

      // Load-use: one bubble, then none with wreg_ex=0.
      ld_ex = 1'b1; wreg_ex = 5'd8; rs_id = 5'd8; rt_id = 5'd3;
      run_cycle();
      clean();
      run_cycle();
      chk("lu_stall1", 64'(stall_cnt), 64'd1);
      ld_ex = 1'b1; wreg_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
      run_cycle();
      chk("lu_r0_nostall", 64'(stall_cnt), 64'd1);

      // Data-memory wait for 3 cycles, then completion.
      clean();
      dREN_mem = 1'b1;
      repeat (3) run_cycle();
      dhit = 1'b1;
      run_cycle();
      chk("dwait_stall4", 64'(stall_cnt), 64'd4);

      // Redirect with pending fetch, then redirect under a memory stall.
      clean();
      ihit = 1'b0; redirect_ex = 1'b1;
      run_cycle();
      chk("redir_nostall", 64'(stall_cnt), 64'd4);
      dREN_mem = 1'b1; dhit = 1'b0;
      run_cycle();
      chk("redir_memstall", 64'(stall_cnt), 64'd5);

      // Halt sequence; counters then freeze under random stimulus.
      clean();
      halt_mem = 1'b1;
      run_cycle();
      clean();
      run_cycle();
      chk("halted_flag", 64'(halt), 64'd1);
      repeat (20) begin
         rand_inputs();
         run_cycle();
      end
      chk("halt_sticky", 64'(halt), 64'd1);

      // Asynchronous reset while draining.
      do_reset();
      clean();
      repeat (3) run_cycle();
      halt_mem = 1'b1;
      run_cycle();
      clean();
      #2;
      chk("drain_pc_en", 64'(pc_en), 64'd0);
      chk("drain_exmem_fl", 64'(exmem_flush), 64'd1);
      nRST = 1'b0;
      #1;
      chk("arst_halt", 64'(halt), 64'd0);
      chk("arst_cyc", 64'(cycle_cnt), 64'd0);
      chk("arst_stall", 64'(stall_cnt), 64'd0);
      chk("arst_run_pc_en", 64'(pc_en), 64'd1);
      chk("arst_run_exmem_fl", 64'(exmem_flush), 64'd0);
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
      model_reset();

      // Randomized episodes against the reference model.
      for (int ep = 0; ep < 6; ep++) begin
         do_reset();
         repeat (200) begin
            rand_inputs();
            run_cycle();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
